// File: rtl/pkt_conc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkt_conc_pkg
// Purpose  : Shared byte-code encodings, FSM state enum and count-width helper
//            for the packet concentrator.
// Revision : 1.0 - initial release
// ============================================================================
package pkt_conc_pkg;

    typedef enum logic [1:0] {
        CODE_SOP = 2'd0,
        CODE_MOP = 2'd1,
        CODE_EOP = 2'd2,
        CODE_BAD = 2'd3
    } code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    // Wide enough to hold the value LANES itself, not just LANES-1.
    function automatic int cnt_width(input int lanes);
        return $clog2(lanes) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conc_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : conc_out_reg
// Purpose  : Single-entry srdy/drdy holding register; payload clears to zero
//            when drained so qualifier bits never linger while invalid.
// Revision : 1.0 - initial release
// ============================================================================
module conc_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_srdy,
    output logic             o_drdy,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_srdy,
    input  logic             i_drdy,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign o_drdy = !r_valid || i_drdy;
    assign o_srdy = r_valid;
    assign o_data = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_srdy && o_drdy) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_drdy) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pkt_concentrator_p.sv
`default_nettype none
// ============================================================================
// Module   : pkt_concentrator_p
// Purpose  : Packs a coded byte stream into LANES-byte words with sop/eop/cnt
//            framing, commit/abort qualifiers and packet-length policing.
// Options  : define CONCENTRATOR_STATS_EN for saturating pkt/abort/drop counters
// Revision : 1.0 - initial release
// ============================================================================
module pkt_concentrator_p
    import pkt_conc_pkg::*;
#(
    parameter int  LANES   = 8,
    parameter int  MAX_LEN = 1522,
    parameter int  LEN_W   = 16,
    localparam int CW      = cnt_width(LANES),
    localparam int DW      = 8*LANES + 2 + CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_srdy,
    output logic          c_drdy,
    input  logic [1:0]    c_code,
    input  logic [7:0]    c_data,
    output logic          p_srdy,
    input  logic          p_drdy,
    output logic [DW-1:0] p_data,
`ifdef CONCENTRATOR_STATS_EN
    output logic [31:0]   pkt_cnt,
    output logic [31:0]   abort_cnt,
    output logic [31:0]   drop_cnt,
`endif
    output logic          p_commit,
    output logic          p_abort
);

    localparam logic [CW-1:0]    c_full_cnt = CW'(LANES);
    localparam logic [LEN_W-1:0] c_max_len  = LEN_W'(MAX_LEN);

    state_t             r_state, w_state_nxt;
    logic [8*LANES-1:0] r_bytes, w_bytes_nxt, w_merged;
    logic [CW-1:0]      r_ptr, w_ptr_nxt, w_ptr_inc;
    logic [LEN_W-1:0]   r_len, w_len_nxt;
    logic               r_first, w_first_nxt;
    code_t              w_code;
    logic               w_full, w_over, w_load;
    logic               w_emit_needed, w_discard, w_accept, w_emit;
    logic               w_commit, w_abort, w_out_drdy;
    logic [DW-1:0]      w_word;
    logic [DW+1:0]      w_out_data;

    assign w_code    = code_t'(c_code);
    assign w_ptr_inc = r_ptr + 1'b1;
    assign w_full    = (w_ptr_inc == c_full_cnt);
    assign w_over    = (r_len >= c_max_len);
    assign w_merged  = r_bytes | ({{(8*(LANES-1)){1'b0}}, c_data} << {r_ptr, 3'b000});

    assign c_drdy    = !w_emit_needed || w_out_drdy;
    assign w_accept  = c_srdy && c_drdy;
    assign w_emit    = w_accept && w_emit_needed;

    always_comb begin
        w_state_nxt   = r_state;
        w_bytes_nxt   = r_bytes;
        w_ptr_nxt     = r_ptr;
        w_len_nxt     = r_len;
        w_first_nxt   = r_first;
        w_load        = 1'b0;
        w_emit_needed = 1'b0;
        w_discard     = 1'b0;
        w_commit      = 1'b0;
        w_abort       = 1'b0;
        w_word        = '0;
        case (r_state)
            ST_IDLE, ST_DROP: begin
                if (w_code == CODE_SOP) begin
                    w_load = 1'b1;
                end else begin
                    w_discard = 1'b1;
                    if (r_state == ST_DROP && w_code == CODE_EOP) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_ACCUM: begin
                if (w_code == CODE_SOP) begin
                    // Old packet is aborted and the new one starts in the same beat.
                    w_emit_needed = 1'b1;
                    w_abort       = 1'b1;
                    w_load        = 1'b1;
                end else if (w_code == CODE_BAD || w_over) begin
                    w_emit_needed = 1'b1;
                    w_abort       = 1'b1;
                    w_state_nxt   = ST_DROP;
                    w_bytes_nxt   = '0;
                    w_ptr_nxt     = '0;
                    w_len_nxt     = '0;
                    w_first_nxt   = 1'b0;
                end else if (w_code == CODE_EOP) begin
                    w_emit_needed = 1'b1;
                    w_commit      = 1'b1;
                    w_word        = {r_first, 1'b1, w_ptr_inc, w_merged};
                    w_state_nxt   = ST_IDLE;
                    w_bytes_nxt   = '0;
                    w_ptr_nxt     = '0;
                    w_len_nxt     = '0;
                    w_first_nxt   = 1'b0;
                end else begin
                    w_len_nxt = r_len + 1'b1;
                    if (w_full) begin
                        w_emit_needed = 1'b1;
                        w_word        = {r_first, 1'b0, w_ptr_inc, w_merged};
                        w_bytes_nxt   = '0;
                        w_ptr_nxt     = '0;
                        w_first_nxt   = 1'b0;
                    end else begin
                        w_bytes_nxt = w_merged;
                        w_ptr_nxt   = w_ptr_inc;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_load) begin
            w_state_nxt = ST_ACCUM;
            w_bytes_nxt = {{(8*(LANES-1)){1'b0}}, c_data};
            w_ptr_nxt   = CW'(1);
            w_len_nxt   = LEN_W'(1);
            w_first_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_bytes <= '0;
            r_ptr   <= '0;
            r_len   <= '0;
            r_first <= 1'b0;
        end else if (w_accept) begin
            r_state <= w_state_nxt;
            r_bytes <= w_bytes_nxt;
            r_ptr   <= w_ptr_nxt;
            r_len   <= w_len_nxt;
            r_first <= w_first_nxt;
        end
    end

    conc_out_reg #(
        .WIDTH (DW + 2)
    ) u_out_reg (
        .clk    (clk),
        .rst    (reset),
        .i_srdy (w_emit),
        .o_drdy (w_out_drdy),
        .i_data ({w_commit, w_abort, w_word}),
        .o_srdy (p_srdy),
        .i_drdy (p_drdy),
        .o_data (w_out_data)
    );

    assign p_commit = w_out_data[DW+1];
    assign p_abort  = w_out_data[DW];
    assign p_data   = w_out_data[DW-1:0];

`ifdef CONCENTRATOR_STATS_EN
    logic [31:0] r_pkt_cnt, r_abort_cnt, r_drop_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_cnt   <= '0;
            r_abort_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (p_srdy && p_drdy && p_commit && r_pkt_cnt != '1) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
            if (p_srdy && p_drdy && p_abort && r_abort_cnt != '1) begin
                r_abort_cnt <= r_abort_cnt + 1'b1;
            end
            if (w_accept && w_discard && r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign pkt_cnt   = r_pkt_cnt;
    assign abort_cnt = r_abort_cnt;
    assign drop_cnt  = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pkt_concentrator_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_concentrator_p
// Purpose  : Directed self-checking bench for pkt_concentrator_p at LANES=4,
//            MAX_LEN=64. Stats checks compile in with CONCENTRATOR_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_concentrator_p;
    import pkt_conc_pkg::*;

    localparam int L  = 4;
    localparam int CW = 3;
    localparam int DW = 8*L + 2 + CW;
    localparam logic [DW+1:0] ABORT_W = {2'b01, {DW{1'b0}}};

    logic          clk = 1'b0;
    logic          reset;
    logic          c_srdy, c_drdy;
    logic [1:0]    c_code;
    logic [7:0]    c_data;
    logic          p_srdy, p_drdy;
    logic [DW-1:0] p_data;
    logic          p_commit, p_abort;
`ifdef CONCENTRATOR_STATS_EN
    logic [31:0]   pkt_cnt, abort_cnt, drop_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    logic [DW+1:0] got_q[$];
    logic [DW+1:0] exp_q[$];

    always #5 clk = ~clk;

    pkt_concentrator_p #(
        .LANES   (L),
        .MAX_LEN (64),
        .LEN_W   (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .c_srdy   (c_srdy),
        .c_drdy   (c_drdy),
        .c_code   (c_code),
        .c_data   (c_data),
        .p_srdy   (p_srdy),
        .p_drdy   (p_drdy),
        .p_data   (p_data),
`ifdef CONCENTRATOR_STATS_EN
        .pkt_cnt  (pkt_cnt),
        .abort_cnt(abort_cnt),
        .drop_cnt (drop_cnt),
`endif
        .p_commit (p_commit),
        .p_abort  (p_abort)
    );

    // Inputs change at posedge+1; transfers are recorded mid-cycle.
    always @(negedge clk) begin
        if (p_srdy && p_drdy) got_q.push_back({p_commit, p_abort, p_data});
        if ((p_commit && p_abort) || (!p_srdy && (p_commit || p_abort))) viol++;
    end

    task automatic send(input logic [1:0] code, input logic [7:0] d);
        bit done;
        done   = 1'b0;
        c_srdy = 1'b1;
        c_code = code;
        c_data = d;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            done = c_drdy;
            @(posedge clk);
            #1;
        end
        c_srdy = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout code=%0d data=%h got no c_drdy, required c_drdy=1", code, d);
        end
    endtask

    task automatic send_pkt(input int n, input logic [7:0] base);
        send(CODE_SOP, base);
        for (int i = 1; i < n - 1; i++) send(CODE_MOP, base + 8'(i));
        send(CODE_EOP, base + 8'(n - 1));
    endtask

    // Expected words for n accepted bytes; good=0 means no closing EOP word.
    task automatic exp_pkt(input int n, input logic [7:0] base, input bit good);
        int words;
        logic [8*L-1:0] b;
        int cnt;
        logic last;
        words = good ? (n + L - 1) / L : n / L;
        for (int w = 0; w < words; w++) begin
            b    = '0;
            cnt  = (n - L*w < L) ? n - L*w : L;
            last = good && (w == words - 1);
            for (int k = 0; k < cnt; k++) b[8*k +: 8] = base + 8'(L*w + k);
            exp_q.push_back({last, 1'b0, (w == 0), last, 3'(cnt), b});
        end
    endtask

    task automatic drain;
        p_drdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        c_srdy = 1'b0;
        c_code = 2'd0;
        c_data = 8'h00;
        p_drdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (c_drdy !== 1'b1) begin bad++; $display("FAIL reset_c_drdy got=%b exp=1", c_drdy); end
        total++; if (p_srdy !== 1'b0) begin bad++; $display("FAIL reset_p_srdy got=%b exp=0", p_srdy); end
        total++; if (p_commit !== 1'b0) begin bad++; $display("FAIL reset_p_commit got=%b exp=0", p_commit); end
        total++; if (p_abort !== 1'b0) begin bad++; $display("FAIL reset_p_abort got=%b exp=0", p_abort); end
        total++; if (p_data !== '0) begin bad++; $display("FAIL reset_p_data got=%h exp=0", p_data); end
        @(posedge clk);
        #1;
        got_q.delete();
        exp_q.delete();
    endtask

`ifdef CONCENTRATOR_STATS_EN
    task automatic test_stats;
        send(CODE_MOP, 8'hE0);
        send(CODE_MOP, 8'hE1);
        send_pkt(3, 8'h01);
        send_pkt(5, 8'h11);
        send_pkt(8, 8'h21);
        send(CODE_SOP, 8'h31); send(CODE_MOP, 8'h32); send(CODE_BAD, 8'h33);
        send(CODE_MOP, 8'h34); send(CODE_EOP, 8'h35);
        drain;
        total++; if (pkt_cnt !== 32'd3) begin bad++; $display("FAIL stats_pkt got=%0d exp=3", pkt_cnt); end
        total++; if (abort_cnt !== 32'd1) begin bad++; $display("FAIL stats_abort got=%0d exp=1", abort_cnt); end
        total++; if (drop_cnt !== 32'd4) begin bad++; $display("FAIL stats_drop got=%0d exp=4", drop_cnt); end
        got_q.delete();
        exp_q.delete();
    endtask
`endif

    task automatic test_multiword;
        send(CODE_SOP, 8'h01);
        send(CODE_EOP, 8'h02);
        @(negedge clk);
        total++;
        if (p_srdy !== 1'b1 || p_commit !== 1'b1) begin
            bad++;
            $display("FAIL latency p_srdy=%b p_commit=%b exp both 1", p_srdy, p_commit);
        end
        @(posedge clk);
        #1;
        exp_pkt(2, 8'h01, 1'b1);
        send_pkt(20, 8'h10); exp_pkt(20, 8'h10, 1'b1);
        send_pkt(10, 8'h40); exp_pkt(10, 8'h40, 1'b1);
        drain;
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL multiword_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL multiword_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_bad;
        send(CODE_SOP, 8'h50); send(CODE_MOP, 8'h51); send(CODE_BAD, 8'h52);
        send(CODE_MOP, 8'h53); send(CODE_EOP, 8'h54);
        exp_q.push_back(ABORT_W);
        send(CODE_MOP, 8'h55); send(CODE_EOP, 8'h56); send(CODE_BAD, 8'h57);
        send_pkt(2, 8'h60); exp_pkt(2, 8'h60, 1'b1);
        drain;
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL bad_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL bad_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_sop_mid;
        send(CODE_SOP, 8'h70); send(CODE_MOP, 8'h71); send(CODE_MOP, 8'h72);
        exp_q.push_back(ABORT_W);
        send_pkt(5, 8'h80); exp_pkt(5, 8'h80, 1'b1);
        drain;
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL sopmid_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL sopmid_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_maxlen;
        send_pkt(65, 8'h00);
        exp_pkt(64, 8'h00, 1'b0);
        exp_q.push_back(ABORT_W);
        send_pkt(64, 8'h90);
        exp_pkt(64, 8'h90, 1'b1);
        drain;
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL maxlen_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL maxlen_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_stall;
        logic [DW-1:0] held;
        held   = '0;
        p_drdy = 1'b0;
        send_pkt(4, 8'hA0); exp_pkt(4, 8'hA0, 1'b1);
        send(CODE_SOP, 8'hB0); send(CODE_MOP, 8'hB1); send(CODE_MOP, 8'hB2);
        c_srdy = 1'b1;
        c_code = CODE_MOP;
        c_data = 8'hB3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                held = p_data;
                total++;
                if (p_data !== exp_q[0][DW-1:0]) begin
                    bad++;
                    $display("FAIL stall_data got=%h exp=%h", p_data, exp_q[0][DW-1:0]);
                end
            end
            total++;
            if (c_drdy !== 1'b0 || p_srdy !== 1'b1 || p_data !== held) begin
                bad++;
                $display("FAIL stall_hold%0d c_drdy=%b p_srdy=%b p_data=%h exp c_drdy=0 p_srdy=1 p_data=%h",
                         i, c_drdy, p_srdy, p_data, held);
            end
            @(posedge clk);
            #1;
        end
        p_drdy = 1'b1;
        send(CODE_MOP, 8'hB3); send(CODE_MOP, 8'hB4); send(CODE_EOP, 8'hB5);
        exp_pkt(6, 8'hB0, 1'b1);
        drain;
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL stall_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid;
        send(CODE_SOP, 8'hC0); send(CODE_MOP, 8'hC1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++;
        if (p_srdy !== 1'b0 || c_drdy !== 1'b1) begin
            bad++;
            $display("FAIL resetmid_state p_srdy=%b c_drdy=%b exp p_srdy=0 c_drdy=1", p_srdy, c_drdy);
        end
        @(posedge clk);
        #1;
        send_pkt(3, 8'hD0); exp_pkt(3, 8'hD0, 1'b1);
        drain;
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL resetmid_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL resetmid_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset;
`ifdef CONCENTRATOR_STATS_EN
        test_stats;
        test_reset;
`endif
        test_multiword;
        test_bad;
        test_sop_mid;
        test_maxlen;
        test_stall;
        test_reset_mid;
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL qualifier_rules got=%0d violations exp=0", viol);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
